// File: rtl/vga_pkg.sv
// Shared timing constants for the VGA timing generator and the payload that
// travels down the sync/video delay line.
package vga_pkg;

    // 800x600 @ 60 Hz (40 MHz pixel clock), used as the generator defaults.
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    // 640x480 @ 60 Hz (25.175 MHz pixel clock).
    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    // Raw (pre-polarity) flags carried from the request side to the video side.
    // All-zero is the idle value: no sync asserted, no active video.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic vidon;
    } vga_stage_t;

    // Total period of one axis: sync + back porch + active + front porch.
    function automatic int vga_total(input int sync_w, input int bp, input int active, input int fp);
        return sync_w + bp + active + fp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the timing generator (master) and the pixel source /
// display consumer (slave).
//
// Handshake: ce is the pixel enable from the consumer side; nothing in the
// generator moves on a clock edge where ce=0. req_valid/req_x/req_y have no
// ready: every ce edge with req_valid=1 is one pixel request that the consumer
// must service so the data lines up LEAD ce cycles later with vidon=1.
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic          ce;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          req_valid;
    logic [CW-1:0] req_x;
    logic [CW-1:0] req_y;
    logic          hsync;
    logic          vsync;
    logic          vidon;
    logic          sof;
    logic          eol;

    modport master (
        input  ce,
        output hc, vc, req_valid, req_x, req_y, hsync, vsync, vidon, sof, eol
    );

    modport slave (
        output ce,
        input  hc, vc, req_valid, req_x, req_y, hsync, vsync, vidon, sof, eol
    );
endinterface

// File: rtl/vga_delay_line.sv
// ce-gated shift register with asynchronous clear. DEPTH=0 is a plain wire so
// the consumer can choose zero-latency video timing.
module vga_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Clock, clear and enable are intentionally not needed here.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, clr, ce};
            assign dout = din;
        end else begin : g_pipe
            logic [W-1:0] stage [DEPTH];

            // Shift one stage per ce edge; clear empties every stage to idle.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else if (ce) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: raw h/v counters, request-side pixel coordinates and
// frame/line pulses, plus syncs and vidon delayed by LEAD ce cycles so that the
// pixel fetched on req_x/req_y is ready when vidon reaches the display.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LEAD     = 2,
    parameter int CW       = 11
) (
    input  logic             clk,
    input  logic             clr,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = vga_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = vga_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int HA0     = H_SYNC + H_BP;
    localparam int VA0     = V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HA_LO  = CW'(HA0);
    localparam logic [CW-1:0] HA_HI  = CW'(HA0 + H_ACTIVE);
    localparam logic [CW-1:0] VA_LO  = CW'(VA0);
    localparam logic [CW-1:0] VA_HI  = CW'(VA0 + V_ACTIVE);
    localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
    localparam logic [CW-1:0] VS_END = CW'(V_SYNC);

    // Totals must be representable by the counters, and LEAD is bounded so the
    // consumer's fetch latency budget stays small.
    generate
        if (H_TOTAL > (1 << CW)) begin : g_bad_h_total
            $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
        end
        if (V_TOTAL > (1 << CW)) begin : g_bad_v_total
            $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
        end
        if (LEAD < 0 || LEAD > 4) begin : g_bad_lead
            $error("vga_timing_gen: LEAD must be within 0..4");
        end
    endgenerate

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          h_act;
    logic          v_act;
    logic          req_valid;
    vga_stage_t    raw;
    vga_stage_t    dly;

    // Pixel/line counters: hc walks the line, vc steps on the line's last pixel.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hc <= '0;
            vc <= '0;
        end else if (vga.ce) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    // Request-side decode of the current position. clr gates the flags so the
    // idle levels show while clear is held even though hc=vc=0 lies in sync.
    always_comb begin
        h_act     = (hc >= HA_LO) && (hc < HA_HI);
        v_act     = (vc >= VA_LO) && (vc < VA_HI);
        req_valid = h_act && v_act && !clr;
        raw       = '0;
        raw.hsync = (hc < HS_END) && !clr;
        raw.vsync = (vc < VS_END) && !clr;
        raw.vidon = req_valid;
    end

    vga_delay_line #(
        .W     ($bits(vga_stage_t)),
        .DEPTH (LEAD)
    ) u_delay (
        .clk  (clk),
        .clr  (clr),
        .ce   (vga.ce),
        .din  (raw),
        .dout (dly)
    );

    assign vga.hc        = hc;
    assign vga.vc        = vc;
    assign vga.req_valid = req_valid;
    assign vga.req_x     = req_valid ? hc - HA_LO : '0;
    assign vga.req_y     = req_valid ? vc - VA_LO : '0;
    assign vga.sof       = vga.ce && !clr && (hc == '0) && (vc == '0);
    assign vga.eol       = vga.ce && !clr && (hc == H_LAST);
    assign vga.hsync     = dly.hsync ~^ HS_POL;
    assign vga.vsync     = dly.vsync ~^ VS_POL;
    assign vga.vidon     = dly.vidon;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock:
//   dut_a: 800x600 defaults, LEAD=2 (first-frame geometry)
//   dut_b: tiny 19x12 frame, LEAD=3, HS_POL=1 (whole frames, ce patterns, clear)
//   dut_c: 640x480 set, LEAD=0 (combinational video side)
// Expected values come from a position model: the n-th ce edge since clear maps
// to a frame position by division, and the video side is the request side of
// position n-LEAD.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int B_HA = 10, B_HFP = 2, B_HS = 3, B_HBP = 4;
    localparam int B_VA = 6,  B_VFP = 1, B_VS = 2, B_VBP = 3;
    localparam int B_LEAD  = 3;
    localparam int B_FRAME = (B_HS + B_HBP + B_HA + B_HFP) * (B_VS + B_VBP + B_VA + B_VFP);

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, lead;
        bit hp, vp;
    } timing_t;

    typedef struct {
        int hc, vc, rx, ry;
        bit rv, hs, vs, vid, sof, eol;
    } exp_t;

    timing_t ta = '{SVGA_H_ACTIVE, SVGA_H_FP, SVGA_H_SYNC, SVGA_H_BP,
                    SVGA_V_ACTIVE, SVGA_V_FP, SVGA_V_SYNC, SVGA_V_BP, 2, 1'b0, 1'b0};
    timing_t tbt = '{B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_LEAD, 1'b1, 1'b0};
    timing_t tc = '{VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
                    VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP, 0, 1'b0, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr_a = 1'b1, clr_b = 1'b1, clr_c = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int na = 0, nb = 0, nc = 0;

    vga_timing_gen_if #(.CW(11)) ia ();
    vga_timing_gen_if #(.CW(6))  ib ();
    vga_timing_gen_if #(.CW(11)) ic ();

    vga_timing_gen #(.CW(11)) dut_a (.clk(clk), .clr(clr_a), .vga(ia.master));

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .HS_POL(1'b1), .VS_POL(1'b0), .LEAD(B_LEAD), .CW(6)
    ) dut_b (.clk(clk), .clr(clr_b), .vga(ib.master));

    vga_timing_gen #(
        .H_ACTIVE(VGA_H_ACTIVE), .H_FP(VGA_H_FP), .H_SYNC(VGA_H_SYNC), .H_BP(VGA_H_BP),
        .V_ACTIVE(VGA_V_ACTIVE), .V_FP(VGA_V_FP), .V_SYNC(VGA_V_SYNC), .V_BP(VGA_V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(0), .CW(11)
    ) dut_c (.clk(clk), .clr(clr_c), .vga(ic.master));

    // ---------------- reference model ----------------
    function automatic exp_t model(input timing_t t, input int n, input bit rst, input bit ce);
        exp_t e;
        int ht, vt, ha0, va0, p, q, qh, qv;
        bit hs_a, vs_a;
        ht  = t.hs + t.hbp + t.ha + t.hfp;
        vt  = t.vs + t.vbp + t.va + t.vfp;
        ha0 = t.hs + t.hbp;
        va0 = t.vs + t.vbp;
        p    = n % (ht * vt);
        e.hc = p % ht;
        e.vc = p / ht;
        e.rv = !rst && e.hc >= ha0 && e.hc < ha0 + t.ha && e.vc >= va0 && e.vc < va0 + t.va;
        e.rx = e.rv ? e.hc - ha0 : 0;
        e.ry = e.rv ? e.vc - va0 : 0;
        e.sof = !rst && ce && p == 0;
        e.eol = !rst && ce && e.hc == ht - 1;
        if (rst || n < t.lead) begin
            hs_a  = 1'b0;
            vs_a  = 1'b0;
            e.vid = 1'b0;
        end else begin
            q  = (n - t.lead) % (ht * vt);
            qh = q % ht;
            qv = q / ht;
            hs_a  = qh < t.hs;
            vs_a  = qv < t.vs;
            e.vid = qh >= ha0 && qh < ha0 + t.ha && qv >= va0 && qv < va0 + t.va;
        end
        e.hs = hs_a ? t.hp : !t.hp;
        e.vs = vs_a ? t.vp : !t.vp;
        return e;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clr_a = 1'b1; clr_b = 1'b1; clr_c = 1'b1;
        ia.ce = 1'b1; ib.ce = 1'b1; ic.ce = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++; if (ia.hc !== 11'd0 || ia.vc !== 11'd0) $display("FAIL reset_a_counters hc=%0d vc=%0d required 0/0", ia.hc, ia.vc); else passed++;
        total++; if (ia.hsync !== 1'b1) $display("FAIL reset_a_hsync got %b required 1", ia.hsync); else passed++;
        total++; if (ia.vsync !== 1'b1) $display("FAIL reset_a_vsync got %b required 1", ia.vsync); else passed++;
        total++; if (ia.vidon !== 1'b0) $display("FAIL reset_a_vidon got %b required 0", ia.vidon); else passed++;
        total++; if (ia.req_valid !== 1'b0) $display("FAIL reset_a_req_valid got %b required 0", ia.req_valid); else passed++;
        total++; if (ia.sof !== 1'b0) $display("FAIL reset_a_sof got %b required 0", ia.sof); else passed++;
        total++; if (ib.hsync !== 1'b0) $display("FAIL reset_b_hsync got %b required 0", ib.hsync); else passed++;
        total++; if (ib.vsync !== 1'b1) $display("FAIL reset_b_vsync got %b required 1", ib.vsync); else passed++;
        total++; if (ib.sof !== 1'b0 || ib.vidon !== 1'b0) $display("FAIL reset_b_sof_vidon got %b%b required 00", ib.sof, ib.vidon); else passed++;
        total++; if (ic.hsync !== 1'b1 || ic.vidon !== 1'b0 || ic.sof !== 1'b0) $display("FAIL reset_c_outputs got %b%b%b required 100", ic.hsync, ic.vidon, ic.sof); else passed++;
        @(negedge clk);
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        ia.ce = 1'b0; ib.ce = 1'b0; ic.ce = 1'b0;
        na = 0; nb = 0; nc = 0;
    endtask

    // dut_a and dut_c run together with ce=1 into the first active lines.
    task automatic test_default_and_lead0();
        exp_t ea, ec;
        logic [50:0] obs, exp_v;
        int first_rv = -1, first_vid = -1, first_hs_low = -1;
        int rv_hc = -1, rv_vc = -1, rv_x = -1, x_at_1015 = -1;
        int hs_low = 0, vs_low = 0, eol_cnt = 0, c_line_vid = 0, c_hmax = 0;
        for (int i = 0; i < 27 * 1056 + 1020; i++) begin
            ia.ce = 1'b1; ic.ce = 1'b1;
            #1;
            ea = model(ta, na, 1'b0, 1'b1);
            ec = model(tc, nc, 1'b0, 1'b1);
            obs   = {ia.hc, ia.vc, ia.req_valid, ia.req_x, ia.req_y, ia.hsync, ia.vsync, ia.vidon, ia.sof, ia.eol};
            exp_v = {11'(ea.hc), 11'(ea.vc), ea.rv, 11'(ea.rx), 11'(ea.ry), ea.hs, ea.vs, ea.vid, ea.sof, ea.eol};
            total++; if (obs !== exp_v) $display("FAIL a_outputs n=%0d got %h required %h", na, obs, exp_v); else passed++;
            obs   = {ic.hc, ic.vc, ic.req_valid, ic.req_x, ic.req_y, ic.hsync, ic.vsync, ic.vidon, ic.sof, ic.eol};
            exp_v = {11'(ec.hc), 11'(ec.vc), ec.rv, 11'(ec.rx), 11'(ec.ry), ec.hs, ec.vs, ec.vid, ec.sof, ec.eol};
            total++; if (obs !== exp_v) $display("FAIL c_outputs n=%0d got %h required %h", nc, obs, exp_v); else passed++;
            total++; if (ic.vidon !== ic.req_valid) $display("FAIL c_vidon_comb n=%0d vidon=%b req_valid=%b", nc, ic.vidon, ic.req_valid); else passed++;
            if (ia.req_valid === 1'b1 && first_rv < 0) begin
                first_rv = na; rv_hc = int'(ia.hc); rv_vc = int'(ia.vc); rv_x = int'(ia.req_x);
            end
            if (ia.vidon === 1'b1 && first_vid < 0) first_vid = na;
            if (ia.hsync === 1'b0 && na < 1056) begin
                hs_low++;
                if (first_hs_low < 0) first_hs_low = na;
            end
            if (ia.vsync === 1'b0) vs_low++;
            if (ia.eol === 1'b1) eol_cnt++;
            if (ia.hc == 11'd1015 && ia.vc == 11'd27) x_at_1015 = int'(ia.req_x);
            if (ic.vc == 11'd35 && ic.vidon === 1'b1) c_line_vid++;
            if (int'(ic.hc) > c_hmax) c_hmax = int'(ic.hc);
            @(posedge clk);
            na++; nc++;
            @(negedge clk);
        end
        ia.ce = 1'b0; ic.ce = 1'b0;
        total++; if (first_rv != 27 * 1056 + 216) $display("FAIL a_first_req_valid got n=%0d required %0d", first_rv, 27 * 1056 + 216); else passed++;
        total++; if (rv_hc != 216 || rv_vc != 27 || rv_x != 0) $display("FAIL a_first_req_pos got hc=%0d vc=%0d x=%0d required 216/27/0", rv_hc, rv_vc, rv_x); else passed++;
        total++; if (first_vid - first_rv != 2) $display("FAIL a_vidon_lead got %0d required 2", first_vid - first_rv); else passed++;
        total++; if (x_at_1015 != 799) $display("FAIL a_req_x_last got %0d required 799", x_at_1015); else passed++;
        total++; if (hs_low != 128 || first_hs_low != 2) $display("FAIL a_hsync_pulse got len=%0d start=%0d required 128/2", hs_low, first_hs_low); else passed++;
        total++; if (vs_low != 4 * 1056) $display("FAIL a_vsync_pulse got %0d required %0d", vs_low, 4 * 1056); else passed++;
        total++; if (eol_cnt != 27) $display("FAIL a_eol_count got %0d required 27", eol_cnt); else passed++;
        total++; if (c_hmax != 799) $display("FAIL c_h_total got max hc %0d required 799", c_hmax); else passed++;
        total++; if (c_line_vid != 640) $display("FAIL c_line_vidon got %0d required 640", c_line_vid); else passed++;
    endtask

    // Drives dut_b with a ce pattern (0: toggle 1/0, 1: random) and checks every cycle.
    task automatic run_b(input int mode, input int cycles);
        exp_t eb;
        logic [30:0] obs, exp_v;
        logic [28:0] snap, now_v;
        logic ce_was;
        int last_sof = -1, sof_cnt = 0, exp_sof = 0;
        for (int i = 0; i < cycles; i++) begin
            ib.ce = (mode == 0) ? ((i % 2) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            eb = model(tbt, nb, 1'b0, ib.ce);
            obs   = {ib.hc, ib.vc, ib.req_valid, ib.req_x, ib.req_y, ib.hsync, ib.vsync, ib.vidon, ib.sof, ib.eol};
            exp_v = {6'(eb.hc), 6'(eb.vc), eb.rv, 6'(eb.rx), 6'(eb.ry), eb.hs, eb.vs, eb.vid, eb.sof, eb.eol};
            total++; if (obs !== exp_v) $display("FAIL b_outputs mode=%0d n=%0d got %h required %h", mode, nb, obs, exp_v); else passed++;
            if (eb.sof) exp_sof++;
            if (ib.sof === 1'b1) begin
                sof_cnt++;
                if (last_sof >= 0) begin
                    total++; if (nb - last_sof != B_FRAME) $display("FAIL b_sof_period got %0d required %0d", nb - last_sof, B_FRAME); else passed++;
                end
                last_sof = nb;
            end
            snap   = obs[30:2];
            ce_was = ib.ce;
            @(posedge clk);
            #1;
            if (!ce_was) begin
                now_v = {ib.hc, ib.vc, ib.req_valid, ib.req_x, ib.req_y, ib.hsync, ib.vsync, ib.vidon};
                total++; if (now_v !== snap) $display("FAIL b_hold n=%0d got %h required %h", nb, now_v, snap); else passed++;
            end else begin
                nb++;
            end
            @(negedge clk);
        end
        ib.ce = 1'b0;
        total++; if (sof_cnt != exp_sof) $display("FAIL b_sof_count mode=%0d got %0d required %0d", mode, sof_cnt, exp_sof); else passed++;
    endtask

    task automatic test_ce_toggle();
        run_b(0, 4 * B_FRAME);
    endtask

    task automatic test_random_ce();
        run_b(1, 3 * B_FRAME);
    endtask

    // Clear dut_b inside the active area, then expect a fresh frame.
    task automatic test_clr_midframe();
        exp_t eb;
        logic [30:0] obs, exp_v;
        bit found = 1'b0;
        int sof_cnt = 0, last_sof = -1;
        for (int i = 0; i < 2 * B_FRAME && !found; i++) begin
            ib.ce = 1'b1;
            #1;
            eb = model(tbt, nb, 1'b0, 1'b1);
            if (eb.hc == 13 && eb.vc == 7) begin
                found = 1'b1;
                total++; if (ib.vidon !== 1'b1 || ib.hc !== 6'd13 || ib.vc !== 6'd7) $display("FAIL b_pre_clr got hc=%0d vc=%0d vidon=%b required 13/7/1", ib.hc, ib.vc, ib.vidon); else passed++;
            end else begin
                @(posedge clk);
                nb++;
                @(negedge clk);
            end
        end
        total++; if (!found) $display("FAIL b_clr_target got not-reached required hc=13 vc=7"); else passed++;
        clr_b = 1'b1;
        #1;
        total++; if (ib.hc !== 6'd0 || ib.vc !== 6'd0) $display("FAIL b_clr_counters got hc=%0d vc=%0d required 0/0", ib.hc, ib.vc); else passed++;
        total++; if (ib.vidon !== 1'b0 || ib.req_valid !== 1'b0) $display("FAIL b_clr_video got vidon=%b req_valid=%b required 0/0", ib.vidon, ib.req_valid); else passed++;
        total++; if (ib.hsync !== 1'b0 || ib.vsync !== 1'b1 || ib.sof !== 1'b0) $display("FAIL b_clr_syncs got hs=%b vs=%b sof=%b required 0/1/0", ib.hsync, ib.vsync, ib.sof); else passed++;
        @(posedge clk);
        @(negedge clk);
        clr_b = 1'b0;
        nb = 0;
        for (int i = 0; i < B_FRAME + 12; i++) begin
            ib.ce = 1'b1;
            #1;
            eb = model(tbt, nb, 1'b0, 1'b1);
            obs   = {ib.hc, ib.vc, ib.req_valid, ib.req_x, ib.req_y, ib.hsync, ib.vsync, ib.vidon, ib.sof, ib.eol};
            exp_v = {6'(eb.hc), 6'(eb.vc), eb.rv, 6'(eb.rx), 6'(eb.ry), eb.hs, eb.vs, eb.vid, eb.sof, eb.eol};
            total++; if (obs !== exp_v) $display("FAIL b_after_clr n=%0d got %h required %h", nb, obs, exp_v); else passed++;
            if (ib.sof === 1'b1) begin
                sof_cnt++;
                last_sof = nb;
            end
            @(posedge clk);
            nb++;
            @(negedge clk);
        end
        ib.ce = 1'b0;
        total++; if (sof_cnt != 2 || last_sof != B_FRAME) $display("FAIL b_clr_next_sof got count=%0d at=%0d required 2/%0d", sof_cnt, last_sof, B_FRAME); else passed++;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    // ---------------- sequence and report ----------------
    initial begin
        ia.ce = 1'b0; ib.ce = 1'b0; ic.ce = 1'b0;
        test_reset();
        test_default_and_lead0();
        test_ce_toggle();
        test_random_ce();
        test_clr_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 800: visible pixels per line.
REQ-002 Parameter H_FP, 40: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, 128: horizontal sync width, in pixels.
REQ-004 Parameter H_BP, 88: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, 600: visible lines per frame.
REQ-006 Parameter V_FP, 1: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, 4: vertical sync width, in lines.
REQ-008 Parameter V_BP, 23: vertical back porch, in lines.
REQ-009 Parameter HS_POL, 0 / VS_POL, 0: sync level during pulse (0 = active-low).
REQ-010 Parameter LEAD, 2: pixel-request lead over video outputs, in ce cycles, range 0..4.
REQ-011 Parameter CW, 11: counter and coordinate width.
REQ-012 clk  in  1  pixel-domain clock, rising edge.
REQ-013 clr  in  1  reset: one clock; reset is asynchronous and active-high.
REQ-014 ce  in  1  pixel enable; all state advances only on clk edges with ce=1.
REQ-015 hc, vc  out  CW each  raw horizontal / vertical counters.
REQ-016 req_valid  out  1  request-side active region.
REQ-017 req_x, req_y  out  CW each  coordinates of the pixel to fetch.
REQ-018 hsync, vsync  out  1 each  delayed syncs, polarity applied.
REQ-019 vidon  out  1  delayed active-video flag.
REQ-020 sof  out  1  one-ce-cycle pulse at hc=0, vc=0 (request side).
REQ-021 eol  out  1  one-ce-cycle pulse at hc=H_TOTAL-1 (request side).

Function
REQ-022 H_TOTAL SHALL equal H_SYNC+H_BP+H_ACTIVE+H_FP, and V_TOTAL likewise; both SHALL fit in CW bits (elaboration-time check).
REQ-023 Line order SHALL be: sync, back porch, active, front porch, with hc=0 at the first sync pixel.
REQ-024 When ce=1, hc SHALL count 0..H_TOTAL-1 and then wrap to 0.
REQ-025 When ce=1 and hc=H_TOTAL-1, vc SHALL advance in the same edge and wrap from V_TOTAL-1 to 0.
REQ-026 When ce=0, every register (counters, pipeline, pulses) SHALL hold its value; sof and eol SHALL also be gated by ce.
REQ-027 Request-side active region SHALL be HA0 <= hc < HA0+H_ACTIVE and VA0 <= vc < VA0+V_ACTIVE, where HA0=H_SYNC+H_BP and VA0=V_SYNC+V_BP.
REQ-028 Inside the active region, req_x SHALL be hc-HA0 and req_y SHALL be vc-VA0; outside it, both SHALL be 0.
REQ-029 req_valid, req_x, req_y, sof and eol SHALL be combinational decodes of the current hc/vc.
REQ-030 Raw hsync_i SHALL be (hc<H_SYNC) and raw vsync_i SHALL be (vc<V_SYNC).
REQ-031 hsync_i, vsync_i and req_valid SHALL pass through a LEAD-stage shift register advanced on ce.
REQ-032 Stage outputs: hsync = delayed hsync_i XNOR HS_POL; vsync = delayed vsync_i XNOR VS_POL; vidon = delayed req_valid.
REQ-033 With LEAD=0 there SHALL be no pipeline stages, and hsync/vsync/vidon SHALL be combinational from the counters.
REQ-034 Over every line, vidon SHALL be high for exactly H_ACTIVE ce cycles on each active line and 0 on blank lines.

Reset
REQ-035 clr=1 SHALL asynchronously set hc=0, vc=0 and all pipeline stages to inactive (sync not asserted, vidon=0).
REQ-036 While clr=1, outputs SHALL read: hsync=!HS_POL, vsync=!VS_POL, vidon=0, req_valid=0, and sof=0 regardless of ce.
REQ-037 After clr is released mid-frame, the first ce edge SHALL start a fresh frame from hc=0, vc=0; no partial-frame recovery is required.

Structure
REQ-038 A shared package vga_pkg SHALL hold the default 800x600@60 timing constants and a second 640x480 constant set.
REQ-039 Sub-module vga_delay_line (parametrised width and depth, ce-gated, async clear) SHALL implement the LEAD pipeline.
REQ-040 The horizontal and vertical counter logic SHALL stay in vga_timing_gen.

Verification
REQ-041 Scenario: defaults, ce=1, run 2 frames -> hc period 1056, vc period 628, sof exactly once per 663168 cycles.
REQ-042 Scenario: defaults, LEAD=2 -> first vidon=1 exactly 2 cycles after req_valid=1 with req_x=0 at hc=216, vc=27.
REQ-043 Scenario: defaults -> hsync low for hc 0..127 (+LEAD), vsync low for vc 0..3, req_x=799 at hc=1015.
REQ-044 Scenario: ce toggled 1/0 every cycle -> all outputs hold on ce=0, timing identical to scenario REQ-041 in ce-counts.
REQ-045 Scenario: clr pulsed at hc=500, vc=300 -> immediate hc=vc=0 and vidon=0; next sof after 663168 ce cycles.
REQ-046 Scenario: 640x480 package set, HS_POL=VS_POL=0, LEAD=0 -> H_TOTAL 800, V_TOTAL 525, vidon combinational with req_valid.
